// File: rtl/act_pkg.sv
// Shared types and constants for the activation SRAM read and write ports.
package act_pkg;

  localparam int ACT_W  = 256;
  localparam int BANK_W = 128;
  localparam int ADDR_W = 15;
  localparam int LEN_W  = 13;

  // Last byte address of a bank; issuing a read here wraps to 0 on the other pair.
  localparam logic [ADDR_W-1:0] PP_ADDR_LIMIT = 15'd32752;
  localparam logic [ADDR_W-1:0] ADDR_STEP     = 15'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One entry of the read-latency pipe: valid, bank pair tag, and whether
  // this read was the last one of its pair.
  typedef struct packed {
    logic vld;
    logic tag;
    logic wrap;
  } rd_tag_t;

endpackage

// File: rtl/act_rd_port_if.sv
// Beat stream from the activation read port to the compute array.
interface act_rd_port_if;
  import act_pkg::*;

  logic [ACT_W-1:0] data_o;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_o, output data_valid, input data_ready);
  modport slave  (input data_o, input data_valid, output data_ready);

endinterface

// File: rtl/act_rd_fifo.sv
// Show-ahead FIFO built as a shift queue: slot 0 is always the head, so the
// output word comes straight from a flop and reads 0 whenever the queue is empty.
module act_rd_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Pop shifts every entry one slot toward the head; push lands in the first free slot.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop && (count_q != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
      count_d        = count_q - CNT_W'(1);
    end
    if (push && (count_d != DEPTH_C)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == count_d) begin
          mem_d[i] = push_data;
        end
      end
      count_d = count_d + CNT_W'(1);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign data_o = mem_q[0];
  assign count  = count_q;

endmodule

// File: rtl/act_rd_port.sv
// Activation read port: bursts reads out of the Ping (banks 0/1) or Pong
// (banks 2/3) pair, buffers the returning beats and streams them to compute.
//
//   state | meaning
//   IDLE  | waiting for rd_start; a zero-length start only pulses done
//   ISSUE | issuing one read per cycle while the FIFO has credit
//   DRAIN | all reads issued, waiting for the last beat to be accepted
module act_rd_port
  import act_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              done,
  output logic              busy,
  output logic              rce_0,
  output logic              rce_1,
  output logic              rce_2,
  output logic              rce_3,
  output logic [ADDR_W-1:0] raddr_0,
  output logic [ADDR_W-1:0] raddr_1,
  output logic [ADDR_W-1:0] raddr_2,
  output logic [ADDR_W-1:0] raddr_3,
  input  logic [BANK_W-1:0] rdata_0,
  input  logic [BANK_W-1:0] rdata_1,
  input  logic [BANK_W-1:0] rdata_2,
  input  logic [BANK_W-1:0] rdata_3,
  output logic [1:0]        bank_free,
  act_rd_port_if.master     out_if
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              pp_q, pp_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d;
  logic [LEN_W-1:0]  accept_left_q, accept_left_d;
  logic              done_q, done_d;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           pipe_d [RD_LAT];

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic              issue;
  logic              wrap;
  logic              accept;
  rd_tag_t           pipe_out;
  logic [ACT_W-1:0]  push_data;

  // Reads already sent to the SRAM whose data has not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i].vld);
    end
  end

  // Only issue when every outstanding read is guaranteed a FIFO slot.
  assign issue     = (state_q == ISSUE) &&
                     ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign wrap      = (rd_addr_q >= PP_ADDR_LIMIT);
  assign accept    = out_if.data_valid & out_if.data_ready;
  assign pipe_out  = pipe_q[RD_LAT-1];
  assign push_data = pipe_out.tag ? {rdata_3, rdata_2} : {rdata_1, rdata_0};

  // Next-state for the burst FSM, address walk, counters and latency pipe.
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    raddr_d       = raddr_q;
    pp_d          = pp_q;
    issue_left_d  = issue_left_q;
    accept_left_d = accept_left_q;
    done_d        = 1'b0;
    pipe_d        = pipe_q;

    pipe_d[0] = '{vld: issue, tag: pp_q, wrap: issue & wrap};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (issue) begin
      raddr_d      = rd_addr_q;
      issue_left_d = issue_left_q - LEN_W'(1);
      if (wrap) begin
        rd_addr_d = '0;
        pp_d      = ~pp_q;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_STEP;
      end
    end

    if (accept) begin
      accept_left_d = accept_left_q - LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_len != '0) begin
            issue_left_d  = rd_len;
            accept_left_d = rd_len;
            state_d       = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue && (issue_left_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && (accept_left_q == LEN_W'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst FSM and datapath registers; reset drops in-flight reads and the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      raddr_q       <= '0;
      pp_q          <= 1'b0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
      done_q        <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      raddr_q       <= raddr_d;
      pp_q          <= pp_d;
      issue_left_q  <= issue_left_d;
      accept_left_q <= accept_left_d;
      done_q        <= done_d;
      pipe_q        <= pipe_d;
    end
  end

  act_rd_fifo #(
    .WIDTH (ACT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_out.vld),
    .push_data (push_data),
    .pop       (accept),
    .data_o    (out_if.data_o),
    .count     (fifo_count)
  );

  assign out_if.data_valid = (fifo_count != '0);

  assign rce_0 = issue & ~pp_q;
  assign rce_1 = issue & ~pp_q;
  assign rce_2 = issue &  pp_q;
  assign rce_3 = issue &  pp_q;

  // The address bus shows the live address while issuing and otherwise holds the last one.
  assign raddr_0 = issue ? rd_addr_q : raddr_q;
  assign raddr_1 = raddr_0;
  assign raddr_2 = raddr_0;
  assign raddr_3 = raddr_0;

  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign bank_free = {pipe_out.vld & pipe_out.wrap & pipe_out.tag,
                      pipe_out.vld & pipe_out.wrap & ~pipe_out.tag};

endmodule

// File: tb/tb_act_rd_port.sv
// Bench for act_rd_port: SRAM model, beat/bank-free scoreboard, directed and random bursts.
module tb_act_rd_port;
  import act_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_start = 1'b0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              done, busy;
  logic              rce_0, rce_1, rce_2, rce_3;
  logic [ADDR_W-1:0] raddr_0, raddr_1, raddr_2, raddr_3;
  logic [BANK_W-1:0] rdata_0, rdata_1, rdata_2, rdata_3;
  logic [1:0]        bank_free;

  act_rd_port_if bus();

  always #5 clk = ~clk;

  act_rd_port dut (
    .clk       (clk),
    .rst       (rst),
    .rd_start  (rd_start),
    .rd_len    (rd_len),
    .done      (done),
    .busy      (busy),
    .rce_0     (rce_0),
    .rce_1     (rce_1),
    .rce_2     (rce_2),
    .rce_3     (rce_3),
    .raddr_0   (raddr_0),
    .raddr_1   (raddr_1),
    .raddr_2   (raddr_2),
    .raddr_3   (raddr_3),
    .rdata_0   (rdata_0),
    .rdata_1   (rdata_1),
    .rdata_2   (rdata_2),
    .rdata_3   (rdata_3),
    .bank_free (bank_free),
    .out_if    (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int unsigned salt;
  int ready_mode = 0;

  int m_addr;
  bit m_pp;
  logic [ACT_W-1:0] exp_q[$];
  logic [1:0]       bf_q[$];
  logic [ADDR_W:0]  iss_q[$];

  int issue_cnt, acc_cnt, done_cnt, first_rce_cyc, first_val_cyc;
  int done_cyc, last_acc_cyc, wrap_cyc, out_cnt, t_start, cur_len;
  bit prev_stall;
  logic [ACT_W-1:0] prev_data;
  logic [ADDR_W:0]  mon_e;
  logic [3:0]       mon_r;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BANK_W-1:0] bank_word(input int bank, input int addr);
    logic [31:0] a;
    a = 32'(addr);
    return {salt, 32'(bank) ^ 32'h5A5A_0000, a, (a * 32'h9E37_79B1) ^ salt ^ 32'(bank)};
  endfunction

  // SRAM: data for an enabled read appears one cycle later; otherwise junk.
  always @(posedge clk) begin
    rdata_0 <= rce_0 ? bank_word(0, int'(raddr_0)) : {$urandom, $urandom, $urandom, $urandom};
    rdata_1 <= rce_1 ? bank_word(1, int'(raddr_1)) : {$urandom, $urandom, $urandom, $urandom};
    rdata_2 <= rce_2 ? bank_word(2, int'(raddr_2)) : {$urandom, $urandom, $urandom, $urandom};
    rdata_3 <= rce_3 ? bank_word(3, int'(raddr_3)) : {$urandom, $urandom, $urandom, $urandom};
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream consumer readiness.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.data_ready = 1'b1;
      1:       bus.data_ready = ($urandom_range(0, 3) != 0);
      default: bus.data_ready = 1'b0;
    endcase
  end

  // Monitor: reads against the expected issue order, beats against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      out_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      mon_r = {rce_3, rce_2, rce_1, rce_0};
      if (mon_r != 4'b0000) begin
        issue_cnt++;
        out_cnt++;
        if (first_rce_cyc < 0) first_rce_cyc = cyc;
        if (iss_q.size() == 0) begin
          chk("rce_extra", 256'(iss_q.size()), 256'(1));
        end else begin
          mon_e = iss_q.pop_front();
          chk("rce_pair", 256'(mon_r), 256'(mon_e[ADDR_W] ? 4'b1100 : 4'b0011));
          chk("raddr", 256'(raddr_0), 256'(mon_e[ADDR_W-1:0]));
          if (mon_e[ADDR_W-1:0] == PP_ADDR_LIMIT) wrap_cyc = cyc;
        end
        chk("raddr_same", 256'({raddr_1, raddr_2, raddr_3}), 256'({3{raddr_0}}));
        chk("outstanding", 256'(out_cnt <= 4), 256'(1));
      end
      if (bank_free != 2'b00) begin
        if (bf_q.size() == 0) chk("bank_free_extra", 256'(bf_q.size()), 256'(1));
        else chk("bank_free", 256'(bank_free), 256'(bf_q.pop_front()));
        chk("bank_free_lat", 256'(cyc), 256'(wrap_cyc + 1));
      end
      if (prev_stall) begin
        chk("stall_valid", 256'(bus.data_valid), 256'(1));
        chk("stall_data", bus.data_o, prev_data);
      end
      if (bus.data_valid && (first_val_cyc < 0)) first_val_cyc = cyc;
      if (bus.data_valid && bus.data_ready) begin
        acc_cnt++;
        out_cnt--;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) chk("beat_extra", 256'(exp_q.size()), 256'(1));
        else chk("beat", bus.data_o, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.data_valid && !bus.data_ready;
      prev_data  = bus.data_o;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: every beat of a burst follows the pair/address walk rules.
  task automatic model_burst(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_pp) exp_q.push_back({bank_word(3, m_addr), bank_word(2, m_addr)});
      else      exp_q.push_back({bank_word(1, m_addr), bank_word(0, m_addr)});
      iss_q.push_back({m_pp, ADDR_W'(m_addr)});
      if (m_addr >= 32752) begin
        bf_q.push_back(m_pp ? 2'b10 : 2'b01);
        m_addr = 0;
        m_pp   = ~m_pp;
      end else begin
        m_addr += 16;
      end
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_pp   = 1'b0;
    exp_q.delete();
    bf_q.delete();
    iss_q.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, 256'({bus.data_valid, done, busy, bank_free, rce_3, rce_2, rce_1, rce_0}), 256'(0));
    chk({tag, "_raddr"}, 256'({raddr_3, raddr_2, raddr_1, raddr_0}), 256'(0));
    chk({tag, "_data"}, bus.data_o, 256'(0));
  endtask

  task automatic start_burst(input int n);
    issue_cnt = 0; acc_cnt = 0; done_cnt = 0;
    first_rce_cyc = -1; first_val_cyc = -1; done_cyc = -1;
    t_start = cyc;
    cur_len = n;
    rd_start = 1'b1;
    rd_len   = LEN_W'(n);
    model_burst(n);
    tick();
    rd_start = 1'b0;
    if (n > 0) chk("busy_on", 256'(busy), 256'(1));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((done_cnt == 0) && (k < 100 + 4 * cur_len)) begin
      tick();
      k++;
    end
    if (done_cnt == 0) chk("done_timeout", 256'(done_cnt), 256'(1));
    tick(3);
    chk("done_once", 256'(done_cnt), 256'(1));
    chk("issues", 256'(issue_cnt), 256'(cur_len));
    chk("accepts", 256'(acc_cnt), 256'(cur_len));
    chk("done_lat", 256'(done_cyc), 256'((cur_len == 0) ? t_start + 1 : last_acc_cyc + 1));
    chk("exp_empty", 256'(exp_q.size()), 256'(0));
    chk("iss_empty", 256'(iss_q.size()), 256'(0));
    chk("bf_empty", 256'(bf_q.size()), 256'(0));
    chk("busy_off", 256'(busy), 256'(0));
  endtask

  initial begin
    int t0;
    int n;
    salt = $urandom;
    model_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_idle("reset");

    // First burst: timing from rd_start.
    ready_mode = 0;
    start_burst(4);
    t0 = t_start;
    wait_done();
    chk("first_rce", 256'(first_rce_cyc), 256'(t0 + 1));
    chk("first_valid", 256'(first_val_cyc), 256'(t0 + 3));
    chk("done_t7", 256'(done_cyc), 256'(t0 + 7));

    // Address persists across bursts.
    start_burst(2);
    wait_done();

    // Walk up to just below the bank limit, then wrap in the middle of a burst.
    n = (32736 - m_addr) / 16;
    start_burst(n);
    wait_done();
    start_burst(3);
    wait_done();

    // Backpressure mid-burst.
    start_burst(8);
    tick(3);
    ready_mode = 2;
    tick(10);
    chk("stall_busy", 256'(busy), 256'(1));
    ready_mode = 0;
    wait_done();

    // Zero-length burst.
    start_burst(0);
    wait_done();

    // A start while busy is ignored.
    start_burst(6);
    rd_start = 1'b1;
    rd_len   = LEN_W'(5);
    tick();
    rd_start = 1'b0;
    wait_done();

    // Reset while draining; the next burst restarts at address 0 on Ping.
    ready_mode = 2;
    start_burst(3);
    tick(6);
    chk("drain_busy", 256'(busy), 256'(1));
    chk("drain_valid", 256'(bus.data_valid), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_idle("rst_mid");
    ready_mode = 0;
    start_burst(2);
    wait_done();

    // Random bursts with random backpressure and stray starts.
    for (int k = 0; k < 30; k++) begin
      ready_mode = $urandom_range(0, 1);
      n = $urandom_range(0, 12);
      start_burst(n);
      if ((n > 0) && ($urandom_range(0, 1) == 1)) begin
        rd_start = 1'b1;
        rd_len   = LEN_W'($urandom_range(1, 8));
        tick();
        rd_start = 1'b0;
      end
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
